regfile_bist_driver: RTL



---
 rtl/regfile_bist_driver.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/regfile_bist_driver.sv
// regfile_bist_driver: two-pass write/readback march BIST sequencer for a
// 32 x 32-bit register file with two read ports.
//   Pass 0 writes SEED+i to every register, pass 1 writes ~(SEED+i); each
//   pass is read back through both ports (A walks up, B walks down) and
//   r0 is expected to read back as zero.
// Optional build macro: REGFILE_BIST_STOP_ON_FAIL_EN -- when defined the
//   run ends on the first mismatching compare instead of running to the end.
module regfile_bist_driver #(
  parameter logic [31:0] SEED     = 32'h1234_5678,
  parameter int          READ_LAT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        test,
  output logic        t_ctrl_writeEnable,
  output logic [4:0]  t_ctrl_writeReg,
  output logic [4:0]  t_ctrl_readRegA,
  output logic [4:0]  t_ctrl_readRegB,
  output logic [31:0] t_data_writeReg,
  input  logic [31:0] t_data_readRegA,
  input  logic [31:0] t_data_readRegB,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  fail_reg,
  output logic [31:0] fail_data,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  // last hold cycle of a read address; read data is compared in that cycle
  localparam logic [7:0] LAT_LAST = 8'(READ_LAT);

  state_t      state, state_nxt;
  logic [4:0]  idx;       // register index within the current pass
  logic        pass_idx;  // 0 = true pattern, 1 = inverted pattern
  logic [7:0]  lat_cnt;   // read-latency hold counter

  logic [4:0]  idx_b;
  logic [31:0] exp_a, exp_b;
  logic        sample, mis_a, mis_b, last_rd;
  logic [8:0]  err_sum;
  logic [7:0]  err_nxt;

  function automatic logic [31:0] pattern(input logic [4:0] r, input logic inv);
    logic [31:0] p;
    p = SEED + {27'd0, r};
    return inv ? ~p : p;
  endfunction

  // expected read values and compare results for the current read step
  always_comb begin
    idx_b   = 5'd31 - idx;
    exp_a   = (idx   == 5'd0) ? 32'd0 : pattern(idx,   pass_idx);
    exp_b   = (idx_b == 5'd0) ? 32'd0 : pattern(idx_b, pass_idx);
    sample  = (state == S_READ) && (lat_cnt == LAT_LAST);
    mis_a   = sample && (t_data_readRegA != exp_a);
    mis_b   = sample && (t_data_readRegB != exp_b);
    last_rd = sample && (idx == 5'd31);
    err_sum = {1'b0, err_count} + 9'(mis_a) + 9'(mis_b);
    err_nxt = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // regfile drives decode straight from state/idx so phases abut with no bubble
  always_comb begin
    t_ctrl_writeEnable = 1'b0;
    t_ctrl_writeReg    = 5'd0;
    t_data_writeReg    = 32'd0;
    t_ctrl_readRegA    = 5'd0;
    t_ctrl_readRegB    = 5'd0;
    if (state == S_WRITE) begin
      t_ctrl_writeEnable = 1'b1;
      t_ctrl_writeReg    = idx;
      t_data_writeReg    = pattern(idx, pass_idx);
    end
    if (state == S_READ) begin
      t_ctrl_readRegA = idx;
      t_ctrl_readRegB = idx_b;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_WRITE;
      S_WRITE: if (idx == 5'd31) state_nxt = S_READ;
      S_READ: begin
        if (last_rd) state_nxt = pass_idx ? S_DONE : S_WRITE;
`ifdef REGFILE_BIST_STOP_ON_FAIL_EN
        if (mis_a || mis_b) state_nxt = S_DONE;
`endif
      end
      S_DONE:  if (!start) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // march counters, status flags and first-failure capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx       <= 5'd0;
      pass_idx  <= 1'b0;
      lat_cnt   <= 8'd0;
      test      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_reg  <= 5'd0;
      fail_data <= 32'd0;
      err_count <= 8'd0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          idx       <= 5'd0;
          pass_idx  <= 1'b0;
          lat_cnt   <= 8'd0;
          test      <= 1'b1;
          busy      <= 1'b1;
          done      <= 1'b0;
          pass      <= 1'b0;
          fail_reg  <= 5'd0;
          fail_data <= 32'd0;
          err_count <= 8'd0;
        end
        S_WRITE: begin
          idx     <= idx + 5'd1;  // wraps 31 -> 0 for the read phase
          lat_cnt <= 8'd0;
        end
        S_READ: begin
          if (sample) begin
            lat_cnt   <= 8'd0;
            idx       <= idx + 5'd1;
            err_count <= err_nxt;
            // err_count saturates and never returns to 0, so 0 means "no failure yet"
            if (err_count == 8'd0 && (mis_a || mis_b)) begin
              fail_reg  <= mis_a ? idx : idx_b;
              fail_data <= mis_a ? t_data_readRegA : t_data_readRegB;
            end
            if (last_rd) pass_idx <= 1'b1;
            if (state_nxt == S_DONE) begin
              test <= 1'b0;
              busy <= 1'b0;
              done <= 1'b1;
              pass <= (err_nxt == 8'd0);
            end
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
